core_run_ctrl: RTL
==================

Name: core_run_ctrl

Overview:
Run-control sequencer for the tiny accumulator core. It streams a program into instruction memory over a byte-wide valid/ready port, then gates core execution with continuous RUN, single-STEP and HALT commands. It also issues a one-cycle core reset after each completed load and counts executed cycles for the debug display. It sits between the top-level pins (ui_in/uio_in) and the core's imem write port and pc/acc/dmem enables.

Parameters:
IMEM_SZ, 16, number of instruction words; a load always writes exactly this many
INST_W, 8, instruction word width
ADDR_W, 4, imem address width (ADDR_W = CLOG2(IMEM_SZ))
CNT_W, 8, width of the executed-cycle counter

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command strobe
cmd  in  2  00 LOAD, 01 RUN, 10 STEP, 11 HALT
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
data_valid  in  1  load byte valid
data_in  in  INST_W  load byte
data_ready  out  1  load byte accepted when data_valid & data_ready
core_done  in  1  core terminated (inverse of the core's pc enable: last slot, branch not taken)
imem_we  out  1  imem write enable
imem_waddr  out  ADDR_W  imem write address
imem_wdata  out  INST_W  imem write data
core_en  out  1  enables pc, acc and dmem updates this cycle
core_rst  out  1  one-cycle reset of pc/acc/dmem
load_done  out  1  one-cycle pulse after the last load byte
state_out  out  3  current state encoding
exec_cnt  out  CNT_W  cycles with core_en high since last core_rst, saturating

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- On rst: state IDLE. load address = 0. exec_cnt = 0. core_en, core_rst, load_done, imem_we = 0.
- rst mid-LOAD or mid-RUN aborts immediately. Already-written imem words are not touched.
- State encoding:
  - IDLE = 0
  - LOAD = 1
  - RUN = 2
  - STEP = 3
  - DONE = 4
- Outputs are Moore from state, except the imem write port, which is combinational on the accepted beat.
- cmd_ready = 1 in every state. A command not listed for a state is accepted and dropped with no effect.
- A command accepted in cycle N takes effect as the state in cycle N+1.
- IDLE:
  - LOAD -> LOAD, load address cleared to 0.
  - RUN -> DONE if core_done, else RUN.
  - STEP -> DONE if core_done, else STEP.
  - HALT -> no-op.
- LOAD:
  - data_ready = 1.
  - On a beat: imem_we = 1, imem_waddr = load address, imem_wdata = data_in, all in the same cycle. Load address then increments.
  - Beat at address IMEM_SZ-1 -> IDLE. In the next cycle, core_rst = 1, load_done = 1 and exec_cnt clears.
  - HALT -> IDLE with no core_rst and no load_done. Partial contents remain in imem.
  - HALT in the same cycle as a beat: the beat is written first. If that beat was the last one, completion takes precedence and core_rst/load_done fire.
  - data_ready = 0 in every other state; beats there are ignored.
- RUN:
  - core_en = 1 every cycle in this state.
  - HALT -> IDLE; core_en is low from the next cycle.
  - core_done -> DONE. core_done and HALT in the same cycle -> DONE.
- STEP:
  - core_en = 1 for exactly one cycle.
  - Next state is DONE if core_done is sampled in that cycle, else IDLE.
- DONE:
  - core_en = 0.
  - LOAD -> LOAD.
  - HALT -> IDLE.
  - RUN and STEP are dropped.
- exec_cnt increments on each cycle with core_en = 1. It holds at 2^CNT_W-1 and does not wrap.
- The block never asserts imem_we and core_en in the same cycle.

Test Plan:
1. Reset, then LOAD and 16 back-to-back bytes 0x5B,0x07,...,0x00 -> imem_waddr 0..15 each with imem_we; core_rst=1 and load_done=1 one cycle after the byte at address 15; state IDLE; exec_cnt=0.
2. Load with data_valid toggling every other cycle, then HALT after 5 beats -> exactly 5 writes (addr 0..4); no core_rst or load_done; state IDLE.
3. After a full load, RUN; drive core_done high 11 cycles later -> core_en high exactly 11 cycles; state DONE; exec_cnt=11; a later RUN is dropped.
4. Three STEP commands spaced 3 cycles apart from IDLE -> three single-cycle core_en pulses; exec_cnt=3; state returns to IDLE each time.
5. RUN, then HALT and core_done asserted in the same cycle -> state DONE; core_en low next cycle. Separately, HALT on the final load beat -> byte written, core_rst and load_done still fire.
6. Assert rst mid-RUN with exec_cnt=0x40, then force 300 RUN cycles -> reset clears to IDLE with exec_cnt=0; after the 300 cycles exec_cnt saturates at 0xFF.

Source files
------------

// File: rtl/core_run_ctrl_if.sv
`default_nettype none
// ============================================================================
// core_run_ctrl_if : command, load-stream and core-control bundle
// Rev 1.0
// ============================================================================
interface core_run_ctrl_if #(
    parameter int INST_W = 8,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 8
);
    logic              cmd_valid;
    logic [1:0]        cmd;
    logic              cmd_ready;
    logic              data_valid;
    logic [INST_W-1:0] data_in;
    logic              data_ready;
    logic              core_done;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [INST_W-1:0] imem_wdata;
    logic              core_en;
    logic              core_rst;
    logic              load_done;
    logic [2:0]        state_out;
    logic [CNT_W-1:0]  exec_cnt;

    modport master (
        output cmd_valid, cmd, data_valid, data_in, core_done,
        input  cmd_ready, data_ready, imem_we, imem_waddr, imem_wdata,
               core_en, core_rst, load_done, state_out, exec_cnt
    );

    modport slave (
        input  cmd_valid, cmd, data_valid, data_in, core_done,
        output cmd_ready, data_ready, imem_we, imem_waddr, imem_wdata,
               core_en, core_rst, load_done, state_out, exec_cnt
    );
endinterface
`default_nettype wire

// File: rtl/core_run_ctrl.sv
`default_nettype none
// ============================================================================
// core_run_ctrl : program loader and RUN/STEP/HALT sequencer for the core
// Rev 1.0
// ============================================================================
module core_run_ctrl #(
    parameter int IMEM_SZ = 16,
    parameter int INST_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int CNT_W   = 8
) (
    input  wire logic      clk,
    input  wire logic      rst,
    core_run_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        STEP = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [1:0]        C_CMD_LOAD  = 2'b00;
    localparam logic [1:0]        C_CMD_RUN   = 2'b01;
    localparam logic [1:0]        C_CMD_STEP  = 2'b10;
    localparam logic [1:0]        C_CMD_HALT  = 2'b11;
    localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(IMEM_SZ - 1);
    localparam logic [CNT_W-1:0]  C_CNT_MAX   = '1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_exec_cnt;
    logic              r_core_en;
    logic              r_core_rst;
    logic              r_load_done;

    logic              w_load;
    logic              w_run;
    logic              w_step;
    logic              w_halt;
    logic              w_beat;
    logic              w_last_beat;
    logic              w_enter_load;
    logic [INST_W-1:0] w_wdata;

    // cmd_ready is tied high, so every strobe is an accepted command
    assign w_load = bus.cmd_valid && (bus.cmd == C_CMD_LOAD);
    assign w_run  = bus.cmd_valid && (bus.cmd == C_CMD_RUN);
    assign w_step = bus.cmd_valid && (bus.cmd == C_CMD_STEP);
    assign w_halt = bus.cmd_valid && (bus.cmd == C_CMD_HALT);

    assign w_beat       = (r_state == LOAD) && bus.data_valid;
    assign w_last_beat  = w_beat && (r_addr == C_LAST_ADDR);
    assign w_enter_load = (r_state != LOAD) && (w_state_nxt == LOAD);
    assign w_wdata      = bus.data_in;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_load)      w_state_nxt = LOAD;
                else if (w_run)  w_state_nxt = bus.core_done ? DONE : RUN;
                else if (w_step) w_state_nxt = bus.core_done ? DONE : STEP;
            end
            // A final beat wins over a simultaneous HALT so the load completes
            LOAD: begin
                if (w_last_beat || w_halt) w_state_nxt = IDLE;
            end
            RUN: begin
                if (bus.core_done) w_state_nxt = DONE;
                else if (w_halt)   w_state_nxt = IDLE;
            end
            STEP: w_state_nxt = bus.core_done ? DONE : IDLE;
            DONE: begin
                if (w_load)      w_state_nxt = LOAD;
                else if (w_halt) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_exec_cnt  <= '0;
            r_core_en   <= 1'b0;
            r_core_rst  <= 1'b0;
            r_load_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_core_en   <= (w_state_nxt == RUN) || (w_state_nxt == STEP);
            r_core_rst  <= w_last_beat;
            r_load_done <= w_last_beat;

            if (w_enter_load)
                r_addr <= '0;
            else if (w_beat)
                r_addr <= r_addr + ADDR_W'(1);

            if (w_last_beat)
                r_exec_cnt <= '0;
            else if (r_core_en && (r_exec_cnt != C_CNT_MAX))
                r_exec_cnt <= r_exec_cnt + CNT_W'(1);
        end
    end

    assign bus.cmd_ready  = 1'b1;
    assign bus.data_ready = (r_state == LOAD);
    assign bus.imem_we    = w_beat;
    assign bus.imem_waddr = r_addr;
    assign bus.imem_wdata = w_wdata;
    assign bus.core_en    = r_core_en;
    assign bus.core_rst   = r_core_rst;
    assign bus.load_done  = r_load_done;
    assign bus.state_out  = r_state;
    assign bus.exec_cnt   = r_exec_cnt;
endmodule
`default_nettype wire
